// File: rtl/fp_subtractor_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_subtractor_seq : multi-cycle IEEE-754 single subtractor, a - b,       |
// |   truncating, valid/ready in and out. Optional FP_SUB_SPECIAL_EN adds    |
// |   inf/NaN short-circuit handling.                                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp_subtractor_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+FRAC_W:0]     a,
  input  logic [EXP_W+FRAC_W:0]     b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     result,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int WORD_W = 1 + EXP_W + FRAC_W;
  localparam int MANT_W = FRAC_W + 1;
  localparam int MAG_W  = MANT_W + 1;
  localparam logic [EXP_W-1:0] EXP_MAX     = '1;
  localparam logic [EXP_W-1:0] SHIFT_LIMIT = EXP_W'(MAG_W);
  localparam logic [EXP_W:0]   WEXP_MAX    = {1'b0, EXP_MAX};
  localparam logic [EXP_W:0]   WEXP_ONE    = {{EXP_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_SUB   = 3'd2,
    S_NORM  = 3'd3,
    S_PACK  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state;
  logic [WORD_W-1:0]    op_a;
  logic [WORD_W-1:0]    op_b;
  logic                 res_sign;
  logic [MANT_W-1:0]    x_mant;
  logic [MANT_W-1:0]    y_mant;
  logic [EXP_W-1:0]     x_exp_r;
  logic [MAG_W-1:0]     mag;
  logic [EXP_W:0]       work_exp;

  // Operand unpack and alignment, evaluated from the captured operands
  logic [EXP_W-1:0]     exp_a;
  logic [EXP_W-1:0]     exp_b;
  logic [MANT_W-1:0]    mant_a;
  logic [MANT_W-1:0]    mant_b;
  logic                 a_ge_b;
  logic [EXP_W-1:0]     x_exp;
  logic [EXP_W-1:0]     y_exp;
  logic [MANT_W-1:0]    x_mant_sel;
  logic [MANT_W-1:0]    y_mant_sel;
  logic [EXP_W-1:0]     exp_diff;
  logic [MANT_W-1:0]    y_shifted;
  logic                 sign_sel;
  logic                 same_sign;
  logic [EXP_W:0]       exp_inc;
  logic [WORD_W-1:0]    pack_value;

  always_comb begin
    exp_a      = op_a[WORD_W-2:FRAC_W];
    exp_b      = op_b[WORD_W-2:FRAC_W];
    mant_a     = (exp_a != '0) ? {1'b1, op_a[FRAC_W-1:0]} : '0;
    mant_b     = (exp_b != '0) ? {1'b1, op_b[FRAC_W-1:0]} : '0;
    a_ge_b     = (op_a[WORD_W-2:0] >= op_b[WORD_W-2:0]);
    x_exp      = a_ge_b ? exp_a  : exp_b;
    y_exp      = a_ge_b ? exp_b  : exp_a;
    x_mant_sel = a_ge_b ? mant_a : mant_b;
    y_mant_sel = a_ge_b ? mant_b : mant_a;
    exp_diff   = x_exp - y_exp;
    y_shifted  = (exp_diff >= SHIFT_LIMIT) ? '0 : (y_mant_sel >> exp_diff);
    sign_sel   = a_ge_b ? op_a[WORD_W-1] : ~op_b[WORD_W-1];
    same_sign  = (op_a[WORD_W-1] == op_b[WORD_W-1]);
    exp_inc    = work_exp + WEXP_ONE;
  end

`ifdef FP_SUB_SPECIAL_EN
  logic                 special;
  logic [WORD_W-1:0]    special_val;
  logic                 a_top;
  logic                 b_top;
  logic                 a_nan;
  logic                 b_nan;
  logic                 special_hit;
  logic [WORD_W-1:0]    special_sel;

  always_comb begin
    a_top       = (exp_a == EXP_MAX);
    b_top       = (exp_b == EXP_MAX);
    a_nan       = a_top && (op_a[FRAC_W-1:0] != '0);
    b_nan       = b_top && (op_b[FRAC_W-1:0] != '0);
    special_hit = a_top || b_top;
    // inf - inf of equal sign has no meaningful value, so it joins NaN
    if (a_nan || b_nan || (a_top && b_top && same_sign))
      special_sel = {1'b0, EXP_MAX, 1'b1, {(FRAC_W-1){1'b0}}};
    else if (a_top)
      special_sel = {op_a[WORD_W-1], EXP_MAX, {FRAC_W{1'b0}}};
    else
      special_sel = {~op_b[WORD_W-1], EXP_MAX, {FRAC_W{1'b0}}};
  end
`endif

  always_comb begin
    pack_value = {res_sign, work_exp[EXP_W-1:0], mag[FRAC_W-1:0]};
    if (overflow)
      pack_value = {res_sign, EXP_MAX, {FRAC_W{1'b0}}};
    else if (underflow || (mag == '0))
      pack_value = '0;
`ifdef FP_SUB_SPECIAL_EN
    if (special)
      pack_value = special_val;
`endif
  end

  assign in_ready = (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      res_sign  <= 1'b0;
      x_mant    <= '0;
      y_mant    <= '0;
      x_exp_r   <= '0;
      mag       <= '0;
      work_exp  <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
`ifdef FP_SUB_SPECIAL_EN
      special     <= 1'b0;
      special_val <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_a      <= a;
            op_b      <= b;
            overflow  <= 1'b0;
            underflow <= 1'b0;
`ifdef FP_SUB_SPECIAL_EN
            special   <= 1'b0;
`endif
            state     <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          res_sign <= sign_sel;
          x_mant   <= x_mant_sel;
          y_mant   <= y_shifted;
          x_exp_r  <= x_exp;
`ifdef FP_SUB_SPECIAL_EN
          if (special_hit) begin
            special     <= 1'b1;
            special_val <= special_sel;
            state       <= S_PACK;
          end else begin
            state <= S_SUB;
          end
`else
          state <= S_SUB;
`endif
        end
        S_SUB: begin
          // Larger magnitude is always X, so the difference cannot go negative
          mag      <= same_sign ? ({1'b0, x_mant} - {1'b0, y_mant})
                                : ({1'b0, x_mant} + {1'b0, y_mant});
          work_exp <= {1'b0, x_exp_r};
          state    <= S_NORM;
        end
        S_NORM: begin
          if (mag == '0) begin
            state <= S_PACK;
          end else if (mag[MAG_W-1]) begin
            mag      <= mag >> 1;
            work_exp <= exp_inc;
            if (exp_inc >= WEXP_MAX)
              overflow <= 1'b1;
            state    <= S_PACK;
          end else if (mag[MANT_W-1]) begin
            state <= S_PACK;
          end else if (work_exp <= WEXP_ONE) begin
            underflow <= 1'b1;
            state     <= S_PACK;
          end else begin
            mag      <= mag << 1;
            work_exp <= work_exp - WEXP_ONE;
          end
        end
        S_PACK: begin
          result    <= pack_value;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
